// File: rtl/lc3b_types.sv
// Shared LC-3b datapath types.
// lc3b_word: 16-bit address/word; lc3b_data: 128-bit cache line.
package lc3b_types;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_data;

endpackage

// File: rtl/l2_arbiter.sv
// l2_arbiter: shares the single L2 request port between the L1 I-cache
// and L1 D-cache, one line transaction outstanding at a time.
// Ports: clk/reset (sync, active-high); icache_* read side;
// dcache_* read/write-back side; l2_* request/response to the L2.
// All outputs are registered; request fields are latched at grant.
module l2_arbiter
  import lc3b_types::*;
(
  input  logic     clk,
  input  logic     reset,
  input  logic     icache_read,
  input  lc3b_word icache_address,
  output lc3b_data icache_rdata,
  output logic     icache_resp,
  input  logic     dcache_read,
  input  logic     dcache_write,
  input  lc3b_word dcache_address,
  input  lc3b_data dcache_wdata,
  input  lc3b_word dcache_byte_enable,
  output lc3b_data dcache_rdata,
  output logic     dcache_resp,
  output logic     l2_read,
  output logic     l2_write,
  output lc3b_word l2_address,
  output lc3b_data l2_wdata,
  output lc3b_word l2_byte_enable,
  input  lc3b_data l2_rdata,
  input  logic     l2_resp
);

  typedef enum logic [1:0] {
    IDLE,
    SERVE_I,
    SERVE_D,
    DONE
  } state_e;

  state_e   state_q, state_d;
  logic     last_grant_q, last_grant_d;
  logic     l2_read_q, l2_read_d;
  logic     l2_write_q, l2_write_d;
  lc3b_word l2_address_q, l2_address_d;
  lc3b_data l2_wdata_q, l2_wdata_d;
  lc3b_word l2_be_q, l2_be_d;
  lc3b_data icache_rdata_q, icache_rdata_d;
  logic     icache_resp_q, icache_resp_d;
  lc3b_data dcache_rdata_q, dcache_rdata_d;
  logic     dcache_resp_q, dcache_resp_d;

  logic d_req;
  logic grant_i;
  logic grant_d;

  // On a tie the side that did not win last time gets the port
  // (last_grant: 0 = I, 1 = D).
  always_comb begin
    d_req   = dcache_read | dcache_write;
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (state_q == IDLE) begin
      if (icache_read && d_req) begin
        grant_d = ~last_grant_q;
        grant_i = last_grant_q;
      end else begin
        grant_i = icache_read;
        grant_d = d_req;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (grant_i) state_d = SERVE_I;
        else if (grant_d) state_d = SERVE_D;
      end
      SERVE_I, SERVE_D: begin
        if (l2_resp) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    last_grant_d   = last_grant_q;
    l2_read_d      = l2_read_q;
    l2_write_d     = l2_write_q;
    l2_address_d   = l2_address_q;
    l2_wdata_d     = l2_wdata_q;
    l2_be_d        = l2_be_q;
    icache_rdata_d = icache_rdata_q;
    dcache_rdata_d = dcache_rdata_q;
    icache_resp_d  = 1'b0;
    dcache_resp_d  = 1'b0;

    if (grant_i) begin
      last_grant_d = 1'b0;
      l2_read_d    = 1'b1;
      l2_write_d   = 1'b0;
      l2_address_d = icache_address;
      l2_wdata_d   = '0;
      l2_be_d      = 16'hFFFF;
    end else if (grant_d) begin
      last_grant_d = 1'b1;
      l2_read_d    = dcache_read;
      l2_write_d   = dcache_write;
      l2_address_d = dcache_address;
      l2_wdata_d   = dcache_wdata;
      l2_be_d      = dcache_write ? dcache_byte_enable
                                  : 16'hFFFF;
    end

    if (l2_resp && state_q == SERVE_I) begin
      icache_rdata_d = l2_rdata;
      icache_resp_d  = 1'b1;
      l2_read_d      = 1'b0;
      l2_write_d     = 1'b0;
    end
    if (l2_resp && state_q == SERVE_D) begin
      dcache_rdata_d = l2_rdata;
      dcache_resp_d  = 1'b1;
      l2_read_d      = 1'b0;
      l2_write_d     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      last_grant_q   <= 1'b0;
      l2_read_q      <= 1'b0;
      l2_write_q     <= 1'b0;
      l2_address_q   <= '0;
      l2_wdata_q     <= '0;
      l2_be_q        <= '0;
      icache_rdata_q <= '0;
      icache_resp_q  <= 1'b0;
      dcache_rdata_q <= '0;
      dcache_resp_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      last_grant_q   <= last_grant_d;
      l2_read_q      <= l2_read_d;
      l2_write_q     <= l2_write_d;
      l2_address_q   <= l2_address_d;
      l2_wdata_q     <= l2_wdata_d;
      l2_be_q        <= l2_be_d;
      icache_rdata_q <= icache_rdata_d;
      icache_resp_q  <= icache_resp_d;
      dcache_rdata_q <= dcache_rdata_d;
      dcache_resp_q  <= dcache_resp_d;
    end
  end

  assign icache_rdata   = icache_rdata_q;
  assign icache_resp    = icache_resp_q;
  assign dcache_rdata   = dcache_rdata_q;
  assign dcache_resp    = dcache_resp_q;
  assign l2_read        = l2_read_q;
  assign l2_write       = l2_write_q;
  assign l2_address     = l2_address_q;
  assign l2_wdata       = l2_wdata_q;
  assign l2_byte_enable = l2_be_q;

endmodule

// File: tb/tb_l2_arbiter.sv
// Self-checking bench for l2_arbiter: vector table of single
// transactions, scoreboard of expected grants, corner sequences.
module tb_l2_arbiter;
  import lc3b_types::*;

  logic     clk = 1'b0;
  logic     reset;
  logic     icache_read;
  lc3b_word icache_address;
  lc3b_data icache_rdata;
  logic     icache_resp;
  logic     dcache_read;
  logic     dcache_write;
  lc3b_word dcache_address;
  lc3b_data dcache_wdata;
  lc3b_word dcache_byte_enable;
  lc3b_data dcache_rdata;
  logic     dcache_resp;
  logic     l2_read;
  logic     l2_write;
  lc3b_word l2_address;
  lc3b_data l2_wdata;
  lc3b_word l2_byte_enable;
  lc3b_data l2_rdata;
  logic     l2_resp;

  l2_arbiter dut (
    .clk                (clk),
    .reset              (reset),
    .icache_read        (icache_read),
    .icache_address     (icache_address),
    .icache_rdata       (icache_rdata),
    .icache_resp        (icache_resp),
    .dcache_read        (dcache_read),
    .dcache_write       (dcache_write),
    .dcache_address     (dcache_address),
    .dcache_wdata       (dcache_wdata),
    .dcache_byte_enable (dcache_byte_enable),
    .dcache_rdata       (dcache_rdata),
    .dcache_resp        (dcache_resp),
    .l2_read            (l2_read),
    .l2_write           (l2_write),
    .l2_address         (l2_address),
    .l2_wdata           (l2_wdata),
    .l2_byte_enable     (l2_byte_enable),
    .l2_rdata           (l2_rdata),
    .l2_resp            (l2_resp)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       is_d;
    bit       rd;
    bit       wr;
    lc3b_word addr;
    lc3b_data wdata;
    lc3b_word be;
    lc3b_data rdata;
    int       lat;
    lc3b_word exp_be;
  } vec_t;

  typedef struct {
    bit       is_d;
    bit       rd;
    bit       wr;
    lc3b_word addr;
    lc3b_data wdata;
    lc3b_word be;
    lc3b_data rdata;
  } exp_t;

  exp_t     sb[$];
  vec_t     vecs[5];
  int       errors = 0;
  int       checks = 0;
  lc3b_data exp_ird;
  lc3b_data exp_drd;

  task automatic chk(input string name,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_quiet(input string name);
    chk({name, "_iresp"}, icache_resp, 1'b0);
    chk({name, "_dresp"}, dcache_resp, 1'b0);
    chk({name, "_strobe"}, {l2_read, l2_write}, 2'b00);
  endtask

  task automatic cmp_grant(input exp_t e, input string name);
    chk({name, "_read"}, l2_read, e.rd);
    chk({name, "_write"}, l2_write, e.wr);
    chk({name, "_addr"}, l2_address, e.addr);
    chk({name, "_wdata"}, l2_wdata, e.wdata);
    chk({name, "_be"}, l2_byte_enable, e.be);
  endtask

  // Called in the DONE cycle, right after the edge that saw l2_resp.
  task automatic chk_done(input exp_t e, input string name);
    if (e.is_d) exp_drd = e.rdata;
    else exp_ird = e.rdata;
    chk({name, "_iresp"}, icache_resp, !e.is_d);
    chk({name, "_dresp"}, dcache_resp, e.is_d);
    chk({name, "_irdata"}, icache_rdata, exp_ird);
    chk({name, "_drdata"}, dcache_rdata, exp_drd);
    chk({name, "_cleared"}, {l2_read, l2_write}, 2'b00);
  endtask

  task automatic push_exp(input vec_t v);
    exp_t e;
    e.is_d  = v.is_d;
    e.rd    = v.rd;
    e.wr    = v.wr;
    e.addr  = v.addr;
    e.wdata = v.wdata;
    e.be    = v.exp_be;
    e.rdata = v.rdata;
    sb.push_back(e);
  endtask

  task automatic run_vec(input vec_t v);
    exp_t e;
    if (v.is_d) begin
      dcache_read        = v.rd;
      dcache_write       = v.wr;
      dcache_address     = v.addr;
      dcache_wdata       = v.wdata;
      dcache_byte_enable = v.be;
    end else begin
      icache_read    = 1'b1;
      icache_address = v.addr;
    end
    push_exp(v);
    tick;
    e = sb.pop_front();
    cmp_grant(e, "grant");
    for (int i = 0; i < v.lat; i++) begin
      chk("serve_resp", {icache_resp, dcache_resp}, 2'b00);
      tick;
      cmp_grant(e, "hold");
    end
    l2_rdata = v.rdata;
    l2_resp  = 1'b1;
    tick;
    l2_resp  = 1'b0;
    l2_rdata = {4{32'hBAD0BAD0}};
    chk_done(e, "done");
    icache_read  = 1'b0;
    dcache_read  = 1'b0;
    dcache_write = 1'b0;
    tick;
    chk_quiet("idle");
  endtask

  // Both sides held high; expected grant order pushed up front.
  task automatic contend(input int n, input bit first_d);
    exp_t e;
    vec_t v;
    bool_loop: begin end
    icache_read    = 1'b1;
    icache_address = 16'h1000;
    dcache_read    = 1'b1;
    dcache_write   = 1'b0;
    dcache_address = 16'h2000;
    dcache_wdata   = 128'h77;
    dcache_byte_enable = 16'h0003;
    for (int k = 0; k < n; k++) begin
      v.is_d   = first_d ^ k[0];
      v.rd     = 1'b1;
      v.wr     = 1'b0;
      v.addr   = v.is_d ? 16'h2000 : 16'h1000;
      v.wdata  = v.is_d ? 128'h77 : 128'h0;
      v.be     = 16'h0;
      v.exp_be = 16'hFFFF;
      v.rdata  = {96'hC0FFEE, k[31:0]};
      v.lat    = 0;
      push_exp(v);
    end
    tick;
    for (int k = 0; k < n; k++) begin
      e = sb.pop_front();
      chk("cont_strobe", l2_read, 1'b1);
      cmp_grant(e, "cont");
      l2_rdata = e.rdata;
      l2_resp  = 1'b1;
      tick;
      l2_resp  = 1'b0;
      chk_done(e, "cont_done");
      tick;
      chk_quiet("cont_gap");
      if (k == n - 1) begin
        icache_read = 1'b0;
        dcache_read = 1'b0;
      end
      tick;
    end
    chk_quiet("cont_end");
  endtask

  initial begin
    reset              = 1'b1;
    icache_read        = 1'b0;
    icache_address     = '0;
    dcache_read        = 1'b0;
    dcache_write       = 1'b0;
    dcache_address     = '0;
    dcache_wdata       = '0;
    dcache_byte_enable = '0;
    l2_rdata           = '0;
    l2_resp            = 1'b0;
    exp_ird            = '0;
    exp_drd            = '0;

    vecs[0] = '{1'b0, 1'b1, 1'b0, 16'h1230, 128'h0, 16'h0,
                {16{8'hA5}}, 1, 16'hFFFF};
    vecs[1] = '{1'b1, 1'b0, 1'b1, 16'hFF00, 128'h1, 16'h00F0,
                128'hDEAD, 3, 16'h00F0};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 16'h0040, 128'h0, 16'h0,
                128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210,
                0, 16'hFFFF};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 16'h3C3C, {4{32'h13579BDF}},
                16'h0F0F, {8{16'h5A5A}}, 2, 16'hFFFF};
    vecs[4] = '{1'b1, 1'b0, 1'b1, 16'h0000, {128{1'b1}},
                16'hFFFF, 128'h42, 0, 16'hFFFF};

    tick;
    tick;
    reset = 1'b0;
    chk_quiet("reset");
    chk("reset_addr", l2_address, 16'h0);
    chk("reset_be", l2_byte_enable, 16'h0);
    chk("reset_wdata", l2_wdata, 128'h0);
    chk("reset_rdata", {icache_rdata, dcache_rdata}, 256'h0);

    // Stray l2_resp while idle must be ignored.
    l2_rdata = {8{16'hEEEE}};
    l2_resp  = 1'b1;
    tick;
    l2_resp  = 1'b0;
    chk_quiet("stray");
    chk("stray_irdata", icache_rdata, exp_ird);
    chk("stray_drdata", dcache_rdata, exp_drd);
    tick;
    chk_quiet("stray2");

    // First tie after reset goes to D, then I.
    contend(2, 1'b1);

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // Reset in the middle of a D write-back.
    dcache_write       = 1'b1;
    dcache_address     = 16'hAAAA;
    dcache_wdata       = 128'h99;
    dcache_byte_enable = 16'h000F;
    tick;
    chk("rst_txn_write", l2_write, 1'b1);
    tick;
    reset = 1'b1;
    tick;
    l2_resp = 1'b1;
    chk_quiet("mid_rst");
    chk("mid_rst_addr", l2_address, 16'h0);
    chk("mid_rst_wdata", l2_wdata, 128'h0);
    chk("mid_rst_be", l2_byte_enable, 16'h0);
    tick;
    l2_resp      = 1'b0;
    reset        = 1'b0;
    dcache_write = 1'b0;
    exp_ird      = '0;
    exp_drd      = '0;
    chk_quiet("mid_rst2");
    chk("mid_rst_rdata", {icache_rdata, dcache_rdata}, 256'h0);
    tick;
    chk_quiet("post_rst");

    // Sustained contention after reset: D, I, D, I, D, I.
    contend(6, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
